// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, issues in-order imem requests and
// queues returned instructions for the IF/ID register, discarding wrong-path fetches.
module fetch_stage #(
    parameter int              XLEN            = 32,
    parameter logic [XLEN-1:0] RESET_PC        = '0,
    parameter int              FIFO_DEPTH      = 2,
    parameter int              MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            stall_if,
    input  logic            redirect_ex,
    input  logic [XLEN-1:0] redirect_ex_pc,
    input  logic            redirect_id,
    input  logic [XLEN-1:0] redirect_id_pc,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] last_pc;
    logic [XLEN-1:0] slot_pc    [FIFO_DEPTH];
    logic [31:0]     slot_instr [FIFO_DEPTH];
    logic [PW-1:0]   head;
    logic [CW-1:0]   alloc_cnt;
    logic [CW-1:0]   fill_cnt;
    logic [OW-1:0]   live_cnt;
    logic [OW-1:0]   drop_cnt;

    logic            redirect;
    logic [XLEN-1:0] target;
    logic            deq;
    logic            credit_ok;
    logic            room_ok;
    logic            handshake;
    logic            rsp_fill;
    logic            rsp_drop;
    logic            rsp_counted;
    logic [PW-1:0]   tail_idx;
    logic [PW-1:0]   fill_idx;

    assign redirect    = redirect_ex || redirect_id;
    assign target      = redirect_ex ? redirect_ex_pc : redirect_id_pc;

    // Slots are allocated and filled strictly in order, so the head plus the two
    // counts locate both the next free slot and the oldest unfilled one.
    assign tail_idx    = head + PW'(alloc_cnt);
    assign fill_idx    = head + PW'(fill_cnt);

    assign if_valid    = (fill_cnt != '0) && !redirect && !rst;
    assign deq         = if_valid && !stall_if;
    assign if_pc       = if_valid ? slot_pc[head] : last_pc;
    assign if_instr    = if_valid ? slot_instr[head] : NOP;

    // A slot freed by this cycle's dequeue may be reused at once; this keeps a
    // two-entry queue streaming one instruction per cycle at unit latency.
    assign credit_ok   = ({1'b0, live_cnt} + {1'b0, drop_cnt}) < (OW+1)'(MAX_OUTSTANDING);
    assign room_ok     = (alloc_cnt - CW'(deq)) < CW'(FIFO_DEPTH);
    assign imem_req_valid = !rst && !redirect && credit_ok && room_ok;
    assign imem_req_addr  = fetch_pc;
    assign handshake   = imem_req_valid && imem_req_ready;

    assign rsp_drop    = imem_rsp_valid && (drop_cnt != '0);
    assign rsp_fill    = imem_rsp_valid && (drop_cnt == '0) && (live_cnt != '0);
    assign rsp_counted = imem_rsp_valid && ((drop_cnt != '0) || (live_cnt != '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc  <= RESET_PC;
            last_pc   <= '0;
            head      <= '0;
            alloc_cnt <= '0;
            fill_cnt  <= '0;
            live_cnt  <= '0;
            drop_cnt  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                slot_pc[i]    <= '0;
                slot_instr[i] <= NOP;
            end
        end else if (redirect) begin
            // Everything still in flight becomes a response to throw away.
            fetch_pc  <= target & ~XLEN'(3);
            alloc_cnt <= '0;
            fill_cnt  <= '0;
            live_cnt  <= '0;
            drop_cnt  <= drop_cnt + live_cnt - OW'(rsp_counted);
        end else begin
            if (handshake) begin
                slot_pc[tail_idx] <= fetch_pc;
                fetch_pc          <= fetch_pc + XLEN'(4);
            end
            if (rsp_fill) begin
                slot_instr[fill_idx] <= imem_rsp_data;
            end
            if (if_valid) begin
                last_pc <= slot_pc[head];
            end
            if (deq) begin
                head <= head + 1'b1;
            end
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - 1'b1;
            end
            alloc_cnt <= alloc_cnt + CW'(handshake) - CW'(deq);
            fill_cnt  <= fill_cnt + CW'(rsp_fill) - CW'(deq);
            live_cnt  <= live_cnt + OW'(handshake) - OW'(rsp_fill);
        end
    end

    a_credit: assert property (@(posedge clk) disable iff (rst)
        ({1'b0, live_cnt} + {1'b0, drop_cnt}) <= (OW+1)'(MAX_OUTSTANDING));
    a_slots: assert property (@(posedge clk) disable iff (rst)
        (fill_cnt <= alloc_cnt) && (alloc_cnt <= CW'(FIFO_DEPTH)));
    a_align: assert property (@(posedge clk) disable iff (rst)
        imem_req_valid |-> (imem_req_addr[1:0] == 2'b00));
    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> ((live_cnt != '0) || (drop_cnt != '0)));

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: an in-order memory model with variable latency
// and a program-order reference of which {pc, instr} the front end should present.
module tb_fetch_stage;

    localparam int          DEPTH   = 2;
    localparam int          MAXOUT  = 2;
    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        stall_if;
    logic        redirect_ex;
    logic [31:0] redirect_ex_pc;
    logic        redirect_id;
    logic [31:0] redirect_id_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    fetch_stage #(
        .XLEN(32), .RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .stall_if(stall_if),
        .redirect_ex(redirect_ex), .redirect_ex_pc(redirect_ex_pc),
        .redirect_id(redirect_id), .redirect_id_pc(redirect_id_pc),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    mem_req_t    mem_q[$];
    int          last_due;
    int          cyc;
    int          n_checks;
    int          n_fail;

    int          lat_min, lat_max, ready_pct, stall_pct, redir_pct;
    bit          force_ex, force_id;
    logic [31:0] force_ex_pc, force_id_pc;
    int          stall_left;
    logic [31:0] stall_trig_pc;
    bit          expect_req_hold;

    logic [31:0] exp_fetch_pc;
    logic [31:0] exp_next_pc;
    logic [31:0] last_valid_pc;
    int          slots_used;
    int          first_hs, first_valid, valid_cnt;

    // Each address maps to a distinct instruction word, so a stale response
    // landing in the wrong slot shows up as an instr/pc disagreement.
    function automatic logic [31:0] instrOf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
                     tag, actual, expected, cyc);
        end
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        stall_if = 1'b0;
        redirect_ex = 1'b0;
        redirect_id = 1'b0;
        redirect_ex_pc = '0;
        redirect_id_pc = '0;
        mem_q.delete();
        last_due = 0;
        #1;
        checkOutput("rst_req_valid", imem_req_valid, 0);
        checkOutput("rst_if_valid", if_valid, 0);
        checkOutput("rst_if_instr", if_instr, NOP);
        cyc++;
        @(negedge clk);
        #1;
        checkOutput("rst_req_valid2", imem_req_valid, 0);
        checkOutput("rst_if_valid2", if_valid, 0);
        checkOutput("rst_if_pc", if_pc, 0);
        checkOutput("rst_if_instr2", if_instr, NOP);
        cyc++;
        exp_fetch_pc  = RST_PC;
        exp_next_pc   = RST_PC;
        last_valid_pc = '0;
        slots_used    = 0;
        first_hs      = -1;
        first_valid   = -1;
        valid_cnt     = 0;
    endtask

    task automatic applyStimulus();
        logic        redir, hs, deq;
        logic [31:0] tgt;
        int          inflight_before;
        @(negedge clk);
        rst = 1'b0;
        imem_req_ready = ($urandom_range(0, 99) < ready_pct);
        redirect_ex    = force_ex || ($urandom_range(0, 99) < redir_pct);
        redirect_id    = force_id || (!force_ex && ($urandom_range(0, 99) < redir_pct));
        redirect_ex_pc = force_ex ? force_ex_pc : $urandom_range(0, 32'h3FFF);
        redirect_id_pc = force_id ? force_id_pc : $urandom_range(0, 32'h3FFF);
        force_ex = 1'b0;
        force_id = 1'b0;
        inflight_before = mem_q.size();
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instrOf(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        if (stall_left > 0 && if_valid && if_pc == stall_trig_pc) begin
            stall_if = 1'b1;
            stall_left--;
            if (stall_left == 0) checkOutput("stall_queue_full", imem_req_valid, 0);
        end else begin
            stall_if = ($urandom_range(0, 99) < stall_pct);
        end
        #1;
        redir = redirect_ex || redirect_id;
        hs    = imem_req_valid && imem_req_ready;
        deq   = if_valid && !stall_if;
        if (redir) begin
            checkOutput("req_in_redirect", imem_req_valid, 0);
            checkOutput("valid_in_redirect", if_valid, 0);
        end
        if (imem_req_valid) checkOutput("req_addr", imem_req_addr, exp_fetch_pc);
        if (hs) begin
            checkOutput("credit", inflight_before < MAXOUT, 1);
            checkOutput("slot_room", (slots_used - int'(deq)) < DEPTH, 1);
        end
        if (expect_req_hold) begin
            checkOutput("req_hold_valid", imem_req_valid, 1);
            checkOutput("req_hold_addr", imem_req_addr, 32'h0000_0400);
            checkOutput("req_hold_no_if", if_valid, 0);
        end
        if (if_valid) begin
            checkOutput("if_pc", if_pc, exp_next_pc);
            checkOutput("if_instr", if_instr, instrOf(exp_next_pc));
        end else begin
            checkOutput("if_pc_hold", if_pc, last_valid_pc);
            checkOutput("if_instr_nop", if_instr, NOP);
        end
        if (hs && first_hs < 0) first_hs = cyc;
        if (if_valid && first_valid < 0) first_valid = cyc;
        if (if_valid) valid_cnt++;
        // Memory accepts whatever handshakes, right or wrong path.
        if (hs) begin
            mem_req_t r;
            r.addr = imem_req_addr;
            r.due  = cyc + $urandom_range(lat_min, lat_max);
            if (r.due <= last_due) r.due = last_due + 1;
            last_due = r.due;
            mem_q.push_back(r);
        end
        if (if_valid) last_valid_pc = if_pc;
        if (redir) begin
            tgt = redirect_ex ? redirect_ex_pc : redirect_id_pc;
            exp_fetch_pc = tgt & 32'hFFFF_FFFC;
            exp_next_pc  = tgt & 32'hFFFF_FFFC;
            slots_used   = 0;
        end else begin
            if (deq) begin
                exp_next_pc = exp_next_pc + 32'd4;
                slots_used--;
            end
            if (hs) begin
                exp_fetch_pc = exp_fetch_pc + 32'd4;
                slots_used++;
            end
        end
        cyc++;
    endtask

    task automatic setKnobs(input int lmin, input int lmax, input int rdy,
                            input int stl, input int rdr);
        lat_min = lmin; lat_max = lmax; ready_pct = rdy; stall_pct = stl; redir_pct = rdr;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0;
        force_ex = 0; force_id = 0; force_ex_pc = '0; force_id_pc = '0;
        stall_left = 0; stall_trig_pc = '0; expect_req_hold = 0;
        setKnobs(1, 1, 100, 0, 0);
        resetDut();

        // Unit latency, always ready: first output two cycles after the first
        // handshake, then one instruction every cycle.
        for (int i = 0; i < 12; i++) applyStimulus();
        checkOutput("first_latency", first_valid - first_hs, 2);
        checkOutput("b2b_count", valid_cnt, 10);

        // Hold the stall for five cycles while 0x8 is presented.
        resetDut();
        stall_trig_pc = 32'h8;
        stall_left = 5;
        for (int i = 0; i < 16; i++) applyStimulus();
        checkOutput("stall_consumed", stall_left, 0);

        // Latency 3, EX redirect with two requests in flight.
        resetDut();
        setKnobs(3, 3, 100, 0, 0);
        for (int i = 0; i < 10 && mem_q.size() != 2; i++) applyStimulus();
        checkOutput("setup_outstanding", mem_q.size(), 2);
        force_ex = 1; force_ex_pc = 32'h100;
        for (int i = 0; i < 15; i++) applyStimulus();

        // Both redirects together, in a cycle that also carries a response.
        setKnobs(2, 3, 100, 0, 0);
        begin
            bit found = 0;
            for (int i = 0; i < 20 && !found; i++) begin
                if (mem_q.size() > 0 && mem_q[0].due == cyc) found = 1;
                else applyStimulus();
            end
            checkOutput("setup_rsp_cycle", found, 1);
        end
        force_ex = 1; force_ex_pc = 32'h200;
        force_id = 1; force_id_pc = 32'h300;
        for (int i = 0; i < 12; i++) applyStimulus();

        // Drain, then JAL redirect to a misaligned target with memory not ready.
        setKnobs(1, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) applyStimulus();
        force_id = 1; force_id_pc = 32'h402;
        applyStimulus();
        expect_req_hold = 1;
        for (int i = 0; i < 4; i++) applyStimulus();
        expect_req_hold = 0;
        setKnobs(1, 1, 100, 0, 0);
        for (int i = 0; i < 8; i++) applyStimulus();

        // Reset mid-stream with two requests outstanding; fetch restarts at RESET_PC.
        setKnobs(3, 3, 100, 0, 0);
        for (int i = 0; i < 10 && mem_q.size() != 2; i++) applyStimulus();
        checkOutput("setup_outstanding2", mem_q.size(), 2);
        resetDut();
        setKnobs(1, 1, 100, 0, 0);
        for (int i = 0; i < 10; i++) applyStimulus();

        // PC wrap past the top of the address space.
        force_ex = 1; force_ex_pc = 32'hFFFF_FFF9;
        for (int i = 0; i < 10; i++) applyStimulus();

        // Random mix of latency, backpressure, stalls and redirects.
        setKnobs(1, 4, 70, 25, 4);
        for (int i = 0; i < 3000; i++) applyStimulus();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end. Owns the PC, issues in-order requests to instruction memory, and buffers returned instructions in a small queue.
- Presents one {pc, instr} per cycle to the IF/ID register.
- Honours the hazard unit's IF stall. Applies redirects from EX (taken branch/JALR) and ID (JAL), discarding all wrong-path fetches including those still in flight.

Parameters:
- XLEN, 32, data/address width
- RESET_PC, 32'h0000_0000, PC loaded on reset
- FIFO_DEPTH, 2, instruction queue entries (power of 2, ≥2)
- MAX_OUTSTANDING, 2, maximum imem requests accepted but not yet answered

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- imem_req_valid  out  1  fetch request
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address (word aligned)
- imem_rsp_valid  in  1  response; in order, no backpressure, latency ≥1 cycle
- imem_rsp_data  in  32  instruction word
- stall_if  in  1  hazard unit stall; holds the output instruction
- redirect_ex  in  1  taken branch/JALR resolved in EX
- redirect_ex_pc  in  XLEN  EX target
- redirect_id  in  1  JAL detected in ID
- redirect_id_pc  in  XLEN  ID target
- if_valid  out  1  if_pc/if_instr valid
- if_pc  out  XLEN  PC of presented instruction
- if_instr  out  32  presented instruction

Behaviour:
- Reset (synchronous, all state):
  - fetch_pc=RESET_PC; queue empty; live_cnt=0; drop_cnt=0.
  - Outputs: imem_req_valid=0, if_valid=0, if_pc=0, if_instr=32'h0000_0013 (NOP).
  - Reset during outstanding traffic: drop_cnt is cleared, not preserved. Memory must also be reset together with this block.
- Queue entries hold {pc, instr, filled}.
  - A slot is allocated with pc=imem_req_addr when a request handshakes (imem_req_valid && imem_req_ready).
  - The slot is filled by the next non-dropped response.
- Request issue: imem_req_valid=1 when all of the following hold:
  - not in reset;
  - no redirect this cycle;
  - live_cnt + drop_cnt < MAX_OUTSTANDING;
  - allocated slots < FIFO_DEPTH.
- imem_req_addr=fetch_pc. On handshake: fetch_pc += 4 (mod 2^XLEN, wrap allowed); live_cnt++.
- Response handling:
  - If drop_cnt>0: drop_cnt--, data discarded.
  - Otherwise: fill the oldest unfilled slot; live_cnt--.
  - Response with live_cnt=drop_cnt=0: ignored, assertion fires.
- Output:
  - if_valid = (head slot filled) && !redirect_ex && !redirect_id.
  - if_pc/if_instr = head contents. When not valid, if_pc holds its last value and if_instr=NOP.
- Dequeue when if_valid && !stall_if.
- Latency:
  - Request handshake at cycle T, response at T+L, if_valid at T+L+1.
  - Steady state is 1 instruction/cycle when L=1, MAX_OUTSTANDING≥2, FIFO_DEPTH≥2.
- Stall (stall_if=1): head held stable. Requests continue until the queue is full, then stop. No loss, no duplication.
- Redirect (redirect_ex || redirect_id):
  - Target: redirect_ex_pc if redirect_ex, else redirect_id_pc. EX has priority when both are asserted.
  - fetch_pc <= {target[XLEN-1:2], 2'b00}.
  - Queue flushed (all slots freed, filled or not).
  - drop_cnt <= drop_cnt + live_cnt − (rsp_valid this cycle ? 1 : 0), counted as dropped regardless. live_cnt <= 0.
  - No request issued in the redirect cycle. The first new-path request is issued the next cycle if credits allow.
  - Redirect overrides stall_if.
- Simultaneous events: a response in the redirect cycle is discarded. Dequeue in the same cycle as a redirect is suppressed because if_valid=0.
- Invariants (asserted):
  - live_cnt + drop_cnt ≤ MAX_OUTSTANDING;
  - filled ≤ allocated ≤ FIFO_DEPTH;
  - imem_req_addr[1:0]=0.

Test Plan:
- Reset release with imem_req_ready=1 and L=1 → requests to 0x0,0x4,0x8…; if_valid first high 2 cycles after the first handshake; back-to-back if_pc 0x0,0x4,0x8 with matching instrs.
- stall_if held 5 cycles at if_pc=0x8 → if_pc/if_instr stay 0x8; at most FIFO_DEPTH slots allocated; after release, sequence continues 0xC,0x10 with no gap or duplicate.
- L=3, redirect_ex to 0x100 while 2 requests are outstanding → both late responses discarded; first if_valid shows if_pc=0x100; no instruction from 0x0–0xC after the redirect.
- redirect_ex (0x200) and redirect_id (0x300) in the same cycle, with a response arriving that cycle → fetch_pc=0x200; response dropped; next if_pc=0x200.
- redirect_id to 0x402 → imem_req_addr=0x400; imem_req_ready held low 4 cycles → imem_req_valid stays high with a stable address; no if_valid until a response arrives.
- rst asserted mid-stream with 2 requests outstanding (memory reset too) → next cycle if_valid=0, if_instr=0x13, imem_req_valid=0; after rst falls, fetch restarts at RESET_PC.
